// File: rtl/ripple_cap_pkg.sv
// Shared defaults, FSM state encoding and modulo-delta helper for ripple_count_capture.
package ripple_cap_pkg;

  localparam int unsigned DefCntW       = 4;
  localparam int unsigned DefAccW       = 16;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefStableCyc  = 2;

  typedef logic [0:0] cap_state_t;
  localparam cap_state_t PRIME = 1'b0;
  localparam cap_state_t RUN   = 1'b1;

  // Forward distance from prev to cur on a counter that wraps at 2^width.
  function automatic logic [31:0] mod_delta(input logic [31:0] cur, input logic [31:0] prev,
                                            input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (cur - prev) & mask;
  endfunction

endpackage

// File: rtl/stable_sync.sv
// Per-bit synchronizer chain followed by a stability filter; emits one accept pulse
// per run of STABLE_CYC identical synchronized samples.
module stable_sync
  import ripple_cap_pkg::*;
#(
  parameter int unsigned W           = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned STABLE_CYC  = DefStableCyc
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_raw,
  output logic         o_accept,
  output logic [W-1:0] o_value
);

  localparam logic [2:0] FillMax = 3'(SYNC_STAGES + 1);
  localparam logic [2:0] RunMax  = 3'(STABLE_CYC);

  logic [W-1:0] r_sync [SYNC_STAGES];
  logic [W-1:0] r_prev;
  logic [2:0]   r_fill;
  logic [2:0]   r_run;
  logic [W-1:0] w_s;
  logic         w_filled;
  logic         w_same;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Ignore the reset zeros still draining out of the chain so they are never accepted.
  assign w_filled = (r_fill == FillMax);
  assign w_same   = w_filled && (w_s == r_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
      r_fill <= '0;
      r_run  <= '0;
    end else begin
      r_sync[0] <= i_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_s;
      if (!w_filled) begin
        r_fill <= r_fill + 3'd1;
      end
      if (!w_same) begin
        r_run <= '0;
      end else if (r_run != RunMax) begin
        r_run <= r_run + 3'd1;
      end
    end
  end

  // Fires only on the cycle the run counter reaches RunMax, then saturates.
  assign o_accept = w_same && (r_run == RunMax - 3'd1);
  assign o_value  = w_s;

endmodule

// File: rtl/ripple_count_capture.sv
// Captures an asynchronous ripple counter, converts accepted values into deltas and totals them.
// Define RIPPLE_CAP_OVF_EN for a wrapping total with a sticky ovf output instead of saturation.
module ripple_count_capture
  import ripple_cap_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned ACC_W       = DefAccW,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned STABLE_CYC  = DefStableCyc
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] ripple_q,
  input  logic [ACC_W-1:0] thresh,
  output logic             upd,
  output logic [CNT_W-1:0] delta,
  output logic [ACC_W-1:0] total,
  output logic             thresh_hit,
  output logic             primed
`ifdef RIPPLE_CAP_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SumW = ACC_W + 1;

  cap_state_t       r_state;
  logic [CNT_W-1:0] r_last;
  logic [CNT_W-1:0] r_delta;
  logic [ACC_W-1:0] r_total;
  logic             r_upd;
  logic             r_hit;

  logic             w_acc;
  logic [CNT_W-1:0] w_acc_val;
  logic [CNT_W-1:0] w_d;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_total_nxt;

  stable_sync #(
    .W           (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .STABLE_CYC  (STABLE_CYC)
  ) u_stable_sync (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (ripple_q),
    .o_accept (w_acc),
    .o_value  (w_acc_val)
  );

  assign w_d   = CNT_W'(mod_delta(32'(w_acc_val), 32'(r_last), CNT_W));
  assign w_sum = {1'b0, r_total} + SumW'(w_d);

`ifdef RIPPLE_CAP_OVF_EN
  assign w_total_nxt = w_sum[ACC_W-1:0];
`else
  assign w_total_nxt = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PRIME;
      r_last  <= '0;
      r_delta <= '0;
      r_total <= '0;
      r_upd   <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      r_hit <= r_hit | (r_total >= thresh);
      // clr takes priority and swallows any coincident accept.
      if (clr) begin
        r_state <= PRIME;
        r_total <= '0;
        r_hit   <= 1'b0;
      end else if (w_acc) begin
        unique case (r_state)
          PRIME: begin
            r_last  <= w_acc_val;
            r_state <= RUN;
          end
          RUN: begin
            r_last  <= w_acc_val;
            r_total <= w_total_nxt;
            if (w_d != '0) begin
              r_delta <= w_d;
              r_upd   <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef RIPPLE_CAP_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (w_acc && (r_state == RUN) && w_sum[ACC_W]) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

  assign upd        = r_upd;
  assign delta      = r_delta;
  assign total      = r_total;
  assign thresh_hit = r_hit;
  assign primed     = (r_state == RUN);

endmodule
